// File: rtl/d8m_frame_gen.sv
// d8m_frame_gen: synthetic D8M sensor source. Produces FVAL/LVAL/DATA raster
// timing with deterministic test patterns so capture-side write logic can be
// exercised without a camera attached. All outputs are registered.
module d8m_frame_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 153,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 20,
    parameter int FV_SETUP = 2,
    parameter int FV_HOLD  = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    input  logic [1:0]  iPAT_SEL,
    output logic [11:0] oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic [15:0] oFRAME_CNT,
    output logic        oFRAME_DONE
);

    // State lengths minus one: the down-counter is reloaded with these on entry
    // and the state is left on the cycle the counter reads zero.
    localparam logic [15:0] LEAD_M1  = 16'(FV_SETUP - 1);
    localparam logic [15:0] HACT_M1  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] HBLK_M1  = 16'(H_BLANK - 1);
    localparam logic [15:0] TRAIL_M1 = 16'(FV_HOLD - 1);
    localparam logic [15:0] VBLK_M1  = 16'(V_BLANK * (H_ACTIVE + H_BLANK) - 1);
    localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FV_LEAD  = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_HBLANK   = 3'd3,
        ST_FV_TRAIL = 3'd4,
        ST_VBLANK   = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [1:0]  pat_r, pat_s;
    logic [15:0] x_r, x_s;
    logic [15:0] y_r, y_s;
    logic [15:0] fcnt_r, fcnt_s;
    logic [11:0] data_r, data_s;
    logic        fval_r, fval_s;
    logic        lval_r, lval_s;
    logic        done_r, done_s;

    // Pixel value for the latched pattern at raster position (x, y).
    function automatic logic [11:0] pattern_pixel(input logic [1:0]  pat,
                                                  input logic [11:0] x,
                                                  input logic [11:0] y,
                                                  input logic [3:0]  fc);
        case (pat)
            2'd0:    return x;
            2'd1:    return y;
            2'd2:    return (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
            default: return {fc, 8'h00};
        endcase
    endfunction

    // Next-state, counter reload and next registered output values.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r - 16'd1;
        pat_s   = pat_r;
        x_s     = 16'd0;
        y_s     = y_r;
        fcnt_s  = fcnt_r;
        done_s  = 1'b0;
        fval_s  = 1'b0;
        lval_s  = 1'b0;
        data_s  = 12'd0;

        case (state_r)
            ST_IDLE: begin
                y_s = 16'd0;
                if (iEN) begin
                    state_s = ST_FV_LEAD;
                    cnt_s   = LEAD_M1;
                    pat_s   = iPAT_SEL;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = 16'd0;
                end
            end
            ST_FV_LEAD: begin
                if (cnt_r == 16'd0) begin
                    state_s = ST_ACTIVE;
                    cnt_s   = HACT_M1;
                    y_s     = 16'd0;
                end else begin
                    state_s = ST_FV_LEAD;
                end
            end
            ST_ACTIVE: begin
                if (cnt_r == 16'd0) begin
                    if (y_r == Y_LAST) begin
                        state_s = ST_FV_TRAIL;
                        cnt_s   = TRAIL_M1;
                    end else begin
                        state_s = ST_HBLANK;
                        cnt_s   = HBLK_M1;
                    end
                end else begin
                    state_s = ST_ACTIVE;
                    x_s     = x_r + 16'd1;
                end
            end
            ST_HBLANK: begin
                if (cnt_r == 16'd0) begin
                    state_s = ST_ACTIVE;
                    cnt_s   = HACT_M1;
                    y_s     = y_r + 16'd1;
                end else begin
                    state_s = ST_HBLANK;
                end
            end
            ST_FV_TRAIL: begin
                if (cnt_r == 16'd0) begin
                    state_s = ST_VBLANK;
                    cnt_s   = VBLK_M1;
                    done_s  = 1'b1;
                    fcnt_s  = fcnt_r + 16'd1;
                    y_s     = 16'd0;
                end else begin
                    state_s = ST_FV_TRAIL;
                end
            end
            ST_VBLANK: begin
                y_s = 16'd0;
                if (cnt_r == 16'd0) begin
                    if (iEN) begin
                        state_s = ST_FV_LEAD;
                        cnt_s   = LEAD_M1;
                        pat_s   = iPAT_SEL;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = 16'd0;
                    end
                end else begin
                    state_s = ST_VBLANK;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 16'd0;
                y_s     = 16'd0;
            end
        endcase

        // Strobes follow the state being entered so they line up with oX/oY.
        case (state_s)
            ST_FV_LEAD:  fval_s = 1'b1;
            ST_ACTIVE:   begin fval_s = 1'b1; lval_s = 1'b1; end
            ST_HBLANK:   fval_s = 1'b1;
            ST_FV_TRAIL: fval_s = 1'b1;
            default:     begin fval_s = 1'b0; lval_s = 1'b0; end
        endcase

        if (lval_s) begin
            data_s = pattern_pixel(pat_r, x_s[11:0], y_s[11:0], fcnt_r[3:0]);
        end else begin
            data_s = 12'd0;
        end
    end

    // State, counters and all outputs registered; async reset clears everything.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            pat_r   <= 2'd0;
            x_r     <= 16'd0;
            y_r     <= 16'd0;
            fcnt_r  <= 16'd0;
            data_r  <= 12'd0;
            fval_r  <= 1'b0;
            lval_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pat_r   <= pat_s;
            x_r     <= x_s;
            y_r     <= y_s;
            fcnt_r  <= fcnt_s;
            data_r  <= data_s;
            fval_r  <= fval_s;
            lval_r  <= lval_s;
            done_r  <= done_s;
        end
    end

    assign oDATA       = data_r;
    assign oFVAL       = fval_r;
    assign oLVAL       = lval_r;
    assign oX          = x_r;
    assign oY          = y_r;
    assign oFRAME_CNT  = fcnt_r;
    assign oFRAME_DONE = done_r;

endmodule

// File: tb/tb_d8m_frame_gen.sv
// tb_d8m_frame_gen: directed bench for d8m_frame_gen with a small raster
// (H_ACTIVE=8, H_BLANK=4, V_ACTIVE=3, V_BLANK=1, FV_SETUP=2, FV_HOLD=2;
// 48-cycle frame period) plus a second instance with H_ACTIVE=16 for the
// checker pattern.
module tb_d8m_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [1:0]  pat_sel;
    logic [11:0] data;
    logic        fval, lval, done;
    logic [15:0] x, y, fcnt;

    logic        rst2_n, en2;
    logic [1:0]  pat2;
    logic [11:0] data2;
    logic        fval2, lval2, done2;
    logic [15:0] x2, y2, fcnt2;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    d8m_frame_gen #(.H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(3), .V_BLANK(1),
                    .FV_SETUP(2), .FV_HOLD(2)) dut (
        .iCLK(clk), .iRST(rst_n), .iEN(en), .iPAT_SEL(pat_sel),
        .oDATA(data), .oFVAL(fval), .oLVAL(lval), .oX(x), .oY(y),
        .oFRAME_CNT(fcnt), .oFRAME_DONE(done)
    );

    d8m_frame_gen #(.H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(3), .V_BLANK(1),
                    .FV_SETUP(2), .FV_HOLD(2)) dut2 (
        .iCLK(clk), .iRST(rst2_n), .iEN(en2), .iPAT_SEL(pat2),
        .oDATA(data2), .oFVAL(fval2), .oLVAL(lval2), .oX(x2), .oY(y2),
        .oFRAME_CNT(fcnt2), .oFRAME_DONE(done2)
    );

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 48-cycle frame of dut starting at the next rising edge. At t=15
    // (inside line 1) iEN and iPAT_SEL are changed to en_mid/pat_mid.
    task automatic run_frame(input logic [1:0] pat, input logic [15:0] fc,
                             input logic en_mid, input logic [1:0] pat_mid,
                             input bit rel);
        logic [15:0] fcn, ex, ey;
        logic [11:0] ed;
        logic        ef, el;
        int          p;
        fcn = fc + 16'd1;
        for (int t = 0; t < 48; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (rel && t == 0) release dut.fcnt_r;
            ef = (t < 36);
            p  = (t >= 2) ? (t - 2) % 12 : 0;
            el = (t >= 2) && (t < 36) && (p < 8);
            ex = el ? 16'(p) : 16'd0;
            ey = (t >= 2 && t < 36) ? 16'((t - 2) / 12) : 16'd0;
            if (!el) begin
                ed = 12'h000;
            end else begin
                case (pat)
                    2'd0:    ed = ex[11:0];
                    2'd1:    ed = ey[11:0];
                    2'd2:    ed = (ex[3] ^ ey[3]) ? 12'hFFF : 12'h000;
                    default: ed = {fc[3:0], 8'h00};
                endcase
            end
            check_value($sformatf("fval t=%0d", t), 32'(fval), 32'(ef));
            check_value($sformatf("lval t=%0d", t), 32'(lval), 32'(el));
            check_value($sformatf("x t=%0d", t), 32'(x), 32'(ex));
            check_value($sformatf("y t=%0d", t), 32'(y), 32'(ey));
            check_value($sformatf("data p%0d t=%0d", pat, t), 32'(data), 32'(ed));
            check_value($sformatf("done t=%0d", t), 32'(done), 32'(t == 36));
            check_value($sformatf("fcnt t=%0d", t), 32'(fcnt),
                        32'((t >= 36) ? fcn : fc));
            if (t == 15) begin
                en      = en_mid;
                pat_sel = pat_mid;
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; pat_sel = 2'd0;
        rst2_n = 1'b1; en2 = 1'b0; pat2 = 2'd0;

        // Reset state.
        #2 rst_n = 1'b0; rst2_n = 1'b0;
        #1;
        check_value("rst fval", 32'(fval), 32'd0);
        check_value("rst lval", 32'(lval), 32'd0);
        check_value("rst data", 32'(data), 32'd0);
        check_value("rst x", 32'(x), 32'd0);
        check_value("rst y", 32'(y), 32'd0);
        check_value("rst fcnt", 32'(fcnt), 32'd0);
        check_value("rst done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; rst2_n = 1'b1;
        @(negedge clk);
        check_value("idle fval", 32'(fval), 32'd0);
        en = 1'b1;

        // Ramp frames, mid-frame pattern changes take effect next frame.
        run_frame(2'd0, 16'd0, 1'b1, 2'd0, 1'b0);
        run_frame(2'd0, 16'd1, 1'b1, 2'd1, 1'b0);
        run_frame(2'd1, 16'd2, 1'b1, 2'd2, 1'b0);
        run_frame(2'd2, 16'd3, 1'b1, 2'd3, 1'b0);
        // iEN dropped during line 1: frame and VBLANK complete, then IDLE.
        run_frame(2'd3, 16'd4, 1'b0, 2'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value($sformatf("idle%0d fval", i), 32'(fval), 32'd0);
            check_value($sformatf("idle%0d lval", i), 32'(lval), 32'd0);
            check_value($sformatf("idle%0d fcnt", i), 32'(fcnt), 32'd5);
        end
        en = 1'b1;
        run_frame(2'd3, 16'd5, 1'b1, 2'd0, 1'b0);

        // Async reset at line 2, pixel 4 (t=30).
        for (int t = 0; t <= 30; t++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_value("pre-rst x", 32'(x), 32'd4);
        check_value("pre-rst y", 32'(y), 32'd2);
        check_value("pre-rst lval", 32'(lval), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_value("arst fval", 32'(fval), 32'd0);
        check_value("arst lval", 32'(lval), 32'd0);
        check_value("arst data", 32'(data), 32'd0);
        check_value("arst x", 32'(x), 32'd0);
        check_value("arst y", 32'(y), 32'd0);
        check_value("arst fcnt", 32'(fcnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(2'd0, 16'd0, 1'b1, 2'd3, 1'b0);

        // Frame counter wrap: preload 0xFFFF across the next frame start.
        force dut.fcnt_r = 16'hFFFF;
        run_frame(2'd3, 16'hFFFF, 1'b1, 2'd3, 1'b1);
        run_frame(2'd3, 16'd0, 1'b0, 2'd3, 1'b0);

        // Checker pattern with H_ACTIVE=16: x=8..15 on line 0 is all ones.
        @(negedge clk);
        pat2 = 2'd2;
        en2  = 1'b1;
        for (int t = 0; t < 18; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (t == 0) begin
                check_value("chk16 fval", 32'(fval2), 32'd1);
                check_value("chk16 lead lval", 32'(lval2), 32'd0);
            end else if (t >= 2) begin
                check_value($sformatf("chk16 lval t=%0d", t), 32'(lval2), 32'd1);
                check_value($sformatf("chk16 x t=%0d", t), 32'(x2), 32'(t - 2));
                check_value($sformatf("chk16 y t=%0d", t), 32'(y2), 32'd0);
                check_value($sformatf("chk16 data t=%0d", t), 32'(data2),
                            (t - 2 >= 8) ? 32'h0000_0FFF : 32'd0);
            end else begin
                check_value("chk16 lead2 lval", 32'(lval2), 32'd0);
            end
        end
        check_value("chk16 fcnt", 32'(fcnt2), 32'd0);
        check_value("chk16 done", 32'(done2), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
